fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/memips_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 99 +++++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memips_pkg.sv
// -----------------------------------------------------------------------------
// memips_pkg
// Shared types and constants for the instruction fetch path.
//   addr_t        : 32-bit byte address
//   inst_t        : 32-bit instruction word
//   RESET_PC      : default first fetch address after reset
//   INST_NOP      : value driven on the decode instruction bus when idle
//   fetch_entry_t : {pc, inst} pair stored in the fetch queues (64 bits)
//   align_pc()    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package memips_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam addr_t RESET_PC = 32'h0000_0000;
    localparam inst_t INST_NOP = 32'h0000_0000;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic addr_t align_pc(input addr_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used twice inside fetch_unit: once as the in-flight
// request tag queue and once as the instruction buffer feeding decode.
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset (pointers and count only)
//   flush      : empties the FIFO; overrides push and pop in the same cycle
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry
//   head       : current head entry (valid while count != 0)
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import memips_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Storage needs no reset: nothing is read until count says it was written.
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

    // The fetch unit's issue rule makes both of these unreachable; if either
    // fires, the occupancy accounting upstream is broken.
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !flush && full && !pop));
    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues word-aligned fetch requests, matches the
// in-order memory responses to their addresses, buffers them and hands them
// to decode. Redirects from execute flush the buffer and discard every
// response still owed for requests issued before the redirect.
//   clk, rst_n         : clock / asynchronous active-low reset
//   imem_req_valid     : fetch request valid
//   imem_req_ready     : memory accepts the request
//   imem_req_addr      : fetch address (always the current pc)
//   imem_resp_valid    : in-order response, never back-pressured
//   imem_resp_data     : instruction word of the response
//   redirect_valid     : redirect from execute
//   redirect_pc        : new fetch address (bits [1:0] ignored)
//   id_valid/id_ready  : decode handshake
//   id_inst, id_pc     : instruction and its address
// -----------------------------------------------------------------------------
module fetch_unit
#(
    parameter logic [31:0] RESET_PC = memips_pkg::RESET_PC,
    parameter int          DEPTH    = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    import memips_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    addr_t        pc_reg;
    logic [CW-1:0] drop_reg;

    logic [CW-1:0] tag_count;
    logic [CW-1:0] buf_count;
    fetch_entry_t  tag_head;
    fetch_entry_t  buf_head;
    fetch_entry_t  tag_wdata;
    fetch_entry_t  buf_wdata;

    logic          req_fire;
    logic          id_fire;
    logic          resp_keep;
    logic [CW:0]   occupancy;
    logic          unused_tag_inst;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign id_fire  = id_valid && id_ready;

    // A response is written to the buffer only if it belongs to the current
    // instruction stream: not in a redirect cycle and not owed to a flushed
    // stream.
    assign resp_keep = imem_resp_valid && !redirect_valid && (drop_reg == '0);

    // Slots already claimed: requests in flight plus buffered instructions,
    // less the one decode is taking this cycle. One extra bit holds 2*DEPTH.
    assign occupancy = {1'b0, tag_count} + {1'b0, buf_count} - (CW+1)'(id_fire);

    // rst_n gates the request so nothing is offered while reset is held.
    assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= align_pc(redirect_pc);
        end else if (req_fire) begin
            pc_reg <= pc_reg + 32'd4;
        end
    end

    // Drop counter: on a redirect every request still in flight after this
    // cycle is stale, including any already being dropped for an earlier
    // redirect, so the count is simply the tag-queue occupancy left over.
    // No request is issued in a redirect cycle, so nothing new is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_reg <= '0;
        end else if (redirect_valid) begin
            drop_reg <= tag_count - CW'(imem_resp_valid);
        end else if (imem_resp_valid && (drop_reg != '0)) begin
            drop_reg <= drop_reg - CW'(1);
        end
    end

    // Tag queue: remembers the address of each accepted request so the
    // in-order response can be paired with its pc. Never flushed; stale tags
    // drain through the drop counter.
    assign tag_wdata = '{pc: pc_reg, inst: INST_NOP};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (tag_wdata),
        .pop       (imem_resp_valid),
        .head      (tag_head),
        .count     (tag_count)
    );

    assign unused_tag_inst = ^tag_head.inst;

    // Instruction buffer: registered hand-off to decode (no response bypass).
    assign buf_wdata = '{pc: tag_head.pc, inst: imem_resp_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data (buf_wdata),
        .pop       (id_fire),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Buffer storage is not reset, so the decode payload is forced to zero
    // whenever nothing valid is presented.
    assign id_valid = (buf_count != '0);
    assign id_inst  = id_valid ? buf_head.inst : INST_NOP;
    assign id_pc    = id_valid ? buf_head.pc   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A queue-based reference model (in-flight
// request list with stale marks, decode buffer list) predicts every output on
// every cycle; hand-computed literals pin the key sequences. Memory returns
// inst_of(addr) after a programmable latency.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          DEPTH       = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_hs  = 0;
    int mem_lat = 1;

    // next-cycle stimulus, applied at the following falling edge
    logic        nx_ready    = 1'b1;
    logic        nx_id_ready = 1'b1;
    logic        nx_redir    = 1'b0;
    logic [31:0] nx_rpc      = 32'h0;

    // values observed in the most recent cycle
    logic        obs_id_valid;
    logic [31:0] obs_id_pc;
    logic        obs_req_valid;

    // ---------------- environment and model ----------------
    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] addr; bit stale; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } buf_t;

    mem_t        mem_q[$];
    out_t        m_out[$];
    buf_t        m_buf[$];
    logic [31:0] m_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit          m_pop;
        bit          exp_req;
        bit          keep;
        out_t        front;
        @(negedge clk);
        imem_req_ready = nx_ready;
        id_ready       = nx_id_ready;
        redirect_valid = nx_redir;
        redirect_pc    = nx_rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hBAD0_BAD0;
        end
        #1;
        obs_id_valid  = id_valid;
        obs_id_pc     = id_pc;
        obs_req_valid = imem_req_valid;

        // expected outputs for this cycle
        m_pop   = (m_buf.size() != 0) && id_ready;
        exp_req = !redirect_valid && ((m_out.size() + m_buf.size() - int'(m_pop)) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            chk("id_pc", id_pc, m_buf[0].pc);
            chk("id_inst", id_inst, m_buf[0].inst);
        end

        // model state advance for the coming rising edge
        keep = 1'b0;
        front = '{addr: 32'h0, stale: 1'b1};
        if (imem_resp_valid) begin
            if (m_out.size() == 0) begin
                chk("resp_without_request", 32'(m_out.size()), 32'd1);
            end else begin
                front = m_out.pop_front();
                keep  = !redirect_valid && !front.stale;
            end
        end
        if (m_pop) void'(m_buf.pop_front());
        if (redirect_valid) begin
            m_buf.delete();
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (exp_req && imem_req_ready) begin
            m_out.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (keep) m_buf.push_back('{pc: front.addr, inst: inst_of(front.addr)});

        // memory answers what the DUT actually issued
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            n_hs++;
        end
        if (id_valid && id_ready) begin
            $display("cycle %0d: decode pc=%h inst=%h", cyc, id_pc, id_inst);
        end
        cyc++;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        nx_redir = 1'b1;
        nx_rpc   = pc;
        step();
        nx_redir = 1'b0;
    endtask

    // Step until decode accepts an instruction, then check its pc.
    task automatic expect_pc(input logic [31:0] exp, input int budget, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            step();
            waited++;
            if (obs_id_valid && id_ready) found = 1'b1;
        end
        if (!found) chk("accept_timeout", 32'(found), 32'd1);
        else        chk("next_pc", obs_id_pc, exp);
    endtask

    // Asserts reset away from the clock edge, checks the outputs react at
    // once, then releases just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n           = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        id_ready        = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, TB_RESET_PC);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        mem_q.delete();
        m_out.delete();
        m_buf.delete();
        m_pc = TB_RESET_PC;
        cyc  = 0;
        n_hs = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;

        // basic streaming from reset, zero-wait memory
        mem_lat = 1; nx_ready = 1'b1; nx_id_ready = 1'b1;
        do_reset();
        expect_pc(32'h0, 5, w);
        chk("first_id_latency", w, 3);
        expect_pc(32'h4, 1, w);
        expect_pc(32'h8, 1, w);
        expect_pc(32'hC, 1, w);

        // decode stalled: at most DEPTH fetched, head held, clean resume
        nx_id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            if (obs_id_valid) chk("stall_hold_pc", obs_id_pc, 32'h0);
        end
        chk("stall_requests", n_hs, DEPTH);
        nx_id_ready = 1'b1;
        expect_pc(32'h0, 1, w);
        expect_pc(32'h4, 1, w);
        expect_pc(32'h8, 1, w);

        // redirect with two requests in flight
        mem_lat = 3;
        do_reset();
        step();
        step();
        chk("two_in_flight", n_hs, 2);
        do_redirect(32'h0000_0103);
        expect_pc(32'h100, 12, w);
        expect_pc(32'h104, 8, w);

        // redirect coincident with a response while decode is accepting
        mem_lat = 1;
        do_reset();
        expect_pc(32'h0, 5, w);
        expect_pc(32'h4, 1, w);
        do_redirect(32'h0000_0200);
        chk("no_req_on_redirect", 32'(obs_req_valid), 32'd0);
        step();
        chk("no_id_after_redirect", 32'(obs_id_valid), 32'd0);
        expect_pc(32'h200, 5, w);

        // back-to-back redirects with slow memory
        mem_lat = 3;
        do_reset();
        step();
        step();
        do_redirect(32'h0000_0040);
        do_redirect(32'h0000_0080);
        expect_pc(32'h80, 12, w);
        expect_pc(32'h84, 8, w);
        expect_pc(32'h88, 8, w);

        // address wrap, misaligned redirect target
        mem_lat = 2;
        do_redirect(32'hFFFF_FFF6);
        expect_pc(32'hFFFF_FFF4, 10, w);
        expect_pc(32'hFFFF_FFF8, 6, w);
        expect_pc(32'hFFFF_FFFC, 6, w);
        expect_pc(32'h0000_0000, 6, w);

        // mixed memory and decode back-pressure, model-checked every cycle
        for (int i = 0; i < 40; i++) begin
            nx_ready    = ((i % 3) != 1);
            nx_id_ready = ((i % 5) < 3);
            step();
        end
        nx_ready = 1'b1; nx_id_ready = 1'b1;

        // reset in the middle of a stream
        mem_lat = 1;
        for (int i = 0; i < 4; i++) step();
        do_reset();
        expect_pc(32'h0, 5, w);
        chk("restart_latency", w, 3);
        expect_pc(32'h4, 1, w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
